spgd_dither_ctrl: RTL and testbench

Single-channel SPGD (stochastic parallel gradient descent) controller directly downstream of the ADC calibration stage. It consumes each calibrated 16Q48 measurement (the value loaded by the calibration register on its write strobe) and drives a DAC code. Each iteration applies a random ±δ dither around a base code, requests two acquisitions, and moves the base code by gain × measured difference.

---
 rtl/spgd_pkg.sv | 20 ++
 rtl/my_mult.sv | 13 +
 rtl/spgd_lfsr.sv | 28 ++
 rtl/spgd_dither_ctrl.sv | 176 +++++++++++++++++
 tb/tb_spgd_dither_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spgd_pkg.sv
// Shared types and constants for the SPGD dither controller.
// Measurements and gain are signed 16Q48.
package spgd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETTLE_A = 3'd1,
      ST_MEAS_A   = 3'd2,
      ST_SETTLE_B = 3'd3,
      ST_MEAS_B   = 3'd4,
      ST_UPDATE   = 3'd5
   } state_e;

   // Right-shifting Fibonacci form of taps 16,14,13,11 (state bits 0,2,3,5)
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   localparam logic [63:0] ONE_Q48   = 64'h0001_0000_0000_0000;
   localparam int          FRAC_BITS = 48;

endpackage

// File: rtl/my_mult.sv
// Signed full-precision multiplier.
// Two Q48 operands give a Q96 product.
module my_mult #(
   parameter int DATA_WIDTH = 64
) (
   input  logic signed [DATA_WIDTH-1:0]   a_in,
   input  logic signed [DATA_WIDTH-1:0]   b_in,
   output logic signed [2*DATA_WIDTH-1:0] prod_out
);

   assign prod_out = a_in * b_in;

endmodule

// File: rtl/spgd_lfsr.sv
// 16-bit Fibonacci LFSR for the dither sign.
// It advances once per shift_en.
module spgd_lfsr
   import spgd_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        shift_en,
   output logic [15:0] state_out
);

   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (shift_en) lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= SEED;
      else     lfsr_q <= lfsr_d;
   end

   assign state_out = lfsr_q;

endmodule

// File: rtl/spgd_dither_ctrl.sv
// SPGD controller. Each iteration dithers the DAC code by +/-delta and measures both points.
// It then moves the base code by gain times the measured difference.
module spgd_dither_ctrl
   import spgd_pkg::*;
#(
   parameter int          FLOAT_WIDTH   = 64,
   parameter int          DAC_WIDTH     = 14,
   parameter int          INIT_CODE     = 8192,
   parameter int          SETTLE_CYCLES = 64,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic                   ADC_CLK,
   input  logic                   RST,
   input  logic                   enable,
   input  logic                   DIR,
   input  logic [DAC_WIDTH-1:0]   PERT_AMP,
   input  logic [FLOAT_WIDTH-1:0] GAIN,
   input  logic [FLOAT_WIDTH-1:0] MEAS_IN,
   input  logic                   MEAS_VALID,
   output logic                   ACQ_START,
   output logic [DAC_WIDTH-1:0]   DAC_CODE_OUT,
   output logic [DAC_WIDTH-1:0]   BASE_CODE,
   output logic [31:0]            ITER_COUNT,
   output logic                   BUSY
);

   localparam int SW    = DAC_WIDTH + 2;
   localparam int FW    = FLOAT_WIDTH;
   localparam int PW    = 2 * FLOAT_WIDTH;
   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [DAC_WIDTH-1:0] CODE_MAX = '1;
   localparam logic signed [SW-1:0] STEP_MAX = {2'b00, CODE_MAX};
   localparam logic signed [PW-1:0] SMAX     = PW'(2**DAC_WIDTH - 1);
   localparam logic signed [PW-1:0] HALF_Q   = PW'(ONE_Q48) <<< (FRAC_BITS - 1);

   function automatic logic [DAC_WIDTH-1:0] clamp(input logic signed [SW-1:0] x);
      if (x[SW-1])                         return '0;
      else if (x > STEP_MAX)               return CODE_MAX;
      else                                 return x[DAC_WIDTH-1:0];
   endfunction

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [DAC_WIDTH-1:0]   dac_q, dac_d, base_q, base_d;
   logic [31:0]            iter_q, iter_d;
   logic                   acq_q, acq_d;
   logic signed [FW-1:0]   ja_q, ja_d, jb_q, jb_d;

   logic                   lfsr_shift, sigma, unused_lfsr;
   logic [15:0]            lfsr_state;

   spgd_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk(ADC_CLK), .rst(RST), .shift_en(lfsr_shift), .state_out(lfsr_state)
   );
   assign sigma       = lfsr_state[0];
   assign unused_lfsr = ^lfsr_state[15:1];

   logic signed [SW-1:0]   base_s, amp_s, step_mag, step;
   logic [DAC_WIDTH-1:0]   code_plus, code_minus, base_upd;
   logic signed [FW:0]     diff_w;
   logic signed [FW-1:0]   diff_sat;
   logic signed [PW-1:0]   prod, rnd;

   my_mult #(.DATA_WIDTH(FLOAT_WIDTH)) u_mult (
      .a_in(diff_sat), .b_in($signed(GAIN)), .prod_out(prod)
   );

   always_comb begin
      base_s     = {2'b00, base_q};
      amp_s      = {2'b00, PERT_AMP};
      code_plus  = clamp(sigma ? base_s + amp_s : base_s - amp_s);
      code_minus = clamp(sigma ? base_s - amp_s : base_s + amp_s);

      diff_w = {ja_q[FW-1], ja_q} - {jb_q[FW-1], jb_q};
      if (diff_w[FW] != diff_w[FW-1])
         diff_sat = diff_w[FW] ? {1'b1, {(FW-1){1'b0}}} : {1'b0, {(FW-1){1'b1}}};
      else
         diff_sat = diff_w[FW-1:0];

      // Product is Q96: add one half, then floor-shift for round-half-up
      rnd = (prod + HALF_Q) >>> (2 * FRAC_BITS);
      if (rnd > SMAX)       step_mag = STEP_MAX;
      else if (rnd < -SMAX) step_mag = -STEP_MAX;
      else                  step_mag = rnd[SW-1:0];

      step     = (sigma == DIR) ? step_mag : -step_mag;
      base_upd = clamp(base_s + step);
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dac_d      = dac_q;
      base_d     = base_q;
      iter_d     = iter_q;
      ja_d       = ja_q;
      jb_d       = jb_q;
      acq_d      = 1'b0;
      lfsr_shift = 1'b0;

      case (state_q)
         ST_IDLE: if (enable) begin
            state_d = ST_SETTLE_A;
            cnt_d   = '0;
            dac_d   = code_plus;
         end
         ST_SETTLE_A, ST_SETTLE_B: begin
            if (cnt_q == CNT_LAST) begin
               state_d = (state_q == ST_SETTLE_A) ? ST_MEAS_A : ST_MEAS_B;
               acq_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_MEAS_A: if (MEAS_VALID) begin
            ja_d    = $signed(MEAS_IN);
            dac_d   = code_minus;
            cnt_d   = '0;
            state_d = ST_SETTLE_B;
         end
         ST_MEAS_B: if (MEAS_VALID) begin
            jb_d    = $signed(MEAS_IN);
            state_d = ST_UPDATE;
         end
         ST_UPDATE: begin
            // The next phase A starts from the bare new base code
            base_d     = base_upd;
            dac_d      = base_upd;
            iter_d     = iter_q + 32'd1;
            lfsr_shift = 1'b1;
            cnt_d      = '0;
            state_d    = enable ? ST_SETTLE_A : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort discards the partial iteration, winning over any capture
      if (!enable && state_q != ST_IDLE && state_q != ST_UPDATE) begin
         state_d = ST_IDLE;
         dac_d   = base_q;
         ja_d    = ja_q;
         jb_d    = jb_q;
         acq_d   = 1'b0;
      end
   end

   always_ff @(posedge ADC_CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dac_q   <= DAC_WIDTH'(INIT_CODE);
         base_q  <= DAC_WIDTH'(INIT_CODE);
         iter_q  <= '0;
         acq_q   <= 1'b0;
         ja_q    <= '0;
         jb_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dac_q   <= dac_d;
         base_q  <= base_d;
         iter_q  <= iter_d;
         acq_q   <= acq_d;
         ja_q    <= ja_d;
         jb_q    <= jb_d;
      end
   end

   assign ACQ_START    = acq_q;
   assign DAC_CODE_OUT = dac_q;
   assign BASE_CODE    = base_q;
   assign ITER_COUNT   = iter_q;
   assign BUSY         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spgd_dither_ctrl.sv
// Directed plus randomized bench for spgd_dither_ctrl against a behavioural SPGD model.
// A second instance with a high INIT_CODE covers clamping.
module tb_spgd_dither_ctrl;

   localparam int S0 = 8;
   localparam int S1 = 3;
   localparam logic [63:0] Q1 = 64'h0001_0000_0000_0000;

   logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, dir = 1'b1, meas_valid = 1'b0;
   logic [13:0] pert = '0;
   logic [63:0] gain = '0, meas_in = '0;

   logic        acq0, busy0, acq1, busy1;
   logic [13:0] dac0, base0, dac1, base1;
   logic [31:0] iter0, iter1;

   always #5 clk = ~clk;

   spgd_dither_ctrl #(.SETTLE_CYCLES(S0)) u0 (
      .ADC_CLK(clk), .RST(rst), .enable(enable), .DIR(dir), .PERT_AMP(pert),
      .GAIN(gain), .MEAS_IN(meas_in), .MEAS_VALID(meas_valid), .ACQ_START(acq0),
      .DAC_CODE_OUT(dac0), .BASE_CODE(base0), .ITER_COUNT(iter0), .BUSY(busy0));

   spgd_dither_ctrl #(.INIT_CODE(16350), .SETTLE_CYCLES(S1)) u1 (
      .ADC_CLK(clk), .RST(rst), .enable(enable), .DIR(dir), .PERT_AMP(pert),
      .GAIN(gain), .MEAS_IN(meas_in), .MEAS_VALID(meas_valid), .ACQ_START(acq1),
      .DAC_CODE_OUT(dac1), .BASE_CODE(base1), .ITER_COUNT(iter1), .BUSY(busy1));

   logic        sel = 1'b0;
   logic        acq_o, busy_o;
   logic [13:0] dac_o, base_o;
   logic [31:0] iter_o;
   assign acq_o  = sel ? acq1  : acq0;
   assign busy_o = sel ? busy1 : busy0;
   assign dac_o  = sel ? dac1  : dac0;
   assign base_o = sel ? base1 : base0;
   assign iter_o = sel ? iter1 : iter0;

   int checks = 0, errors = 0;

   // reference model state
   int          m_base;
   logic [31:0] m_iter;
   logic [15:0] m_lfsr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int mclamp(input int x);
      return (x < 0) ? 0 : ((x > 16383) ? 16383 : x);
   endfunction

   function automatic void m_reset();
      m_base = sel ? 16350 : 8192;
      m_iter = 0;
      m_lfsr = 16'hACE1;
   endfunction

   function automatic void m_update(input logic [63:0] ja, input logic [63:0] jb);
      logic signed [64:0]  dw, maxv, minv;
      logic signed [63:0]  d;
      logic signed [127:0] p, r;
      int s, sg, step;
      logic fb;
      maxv = {2'b00, {63{1'b1}}};
      minv = {2'b11, {63{1'b0}}};
      dw   = $signed({ja[63], ja}) - $signed({jb[63], jb});
      d    = (dw > maxv) ? maxv[63:0] : ((dw < minv) ? minv[63:0] : dw[63:0]);
      p    = d * $signed(gain);
      r    = (p + (128'sd1 <<< 95)) >>> 96;
      s    = (r > 16383) ? 16383 : ((r < -16383) ? -16383 : int'(r));
      sg   = m_lfsr[0] ? 1 : -1;
      step = dir ? sg * s : -sg * s;
      m_base = mclamp(m_base + step);
      m_iter = m_iter + 1;
      fb     = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
      m_lfsr = {fb, m_lfsr[15:1]};
   endfunction

   task automatic wait_acq(output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!acq_o && k < 100);
      checks++;
      assert (acq_o === 1'b1) else begin
         errors++;
         $error("FAIL acq_timeout observed=%0b expected=1", acq_o);
      end
   endtask

   task automatic pulse(input logic [63:0] v);
      meas_in    = v;
      meas_valid = 1'b1;
      @(negedge clk);
      meas_valid = 1'b0;
   endtask

   task automatic do_reset();
      enable = 1'b0;
      meas_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_reset();
   endtask

   // Latencies are counted in negedges from the cycle the DAC code changes.
   task automatic run_iter(input logic [63:0] ja, input logic [63:0] jb,
                           input bit from_idle, input bit stray);
      int k, sg, sc, ea, eb;
      sc = sel ? S1 : S0;
      sg = m_lfsr[0] ? 1 : -1;
      if (from_idle) begin
         ea = mclamp(m_base + sg * int'(pert));
         enable = 1'b1;
         if (stray) begin
            @(negedge clk);
            meas_in = 64'hDEAD_BEEF_0000_1234;
            meas_valid = 1'b1;
            @(negedge clk);
            meas_valid = 1'b0;
         end
         wait_acq(k);
         chk("lat_a", k, stray ? sc - 1 : sc + 1);
      end else begin
         ea = m_base;
         wait_acq(k);
         chk("lat_a", k, sc);
      end
      chk("dac_a", dac_o, ea);
      eb = mclamp(m_base - sg * int'(pert));
      pulse(ja);
      wait_acq(k);
      chk("lat_b", k, sc);
      chk("dac_b", dac_o, eb);
      pulse(jb);
      @(negedge clk);
      m_update(ja, jb);
      chk("base", base_o, m_base);
      chk("iter", iter_o, m_iter);
      chk("dac_upd", dac_o, m_base);
   endtask

   initial begin
      int k;
      int saved;
      logic [63:0] ja;

      repeat (2) @(negedge clk);
      chk("rst_dac0", dac0, 8192);
      chk("rst_base0", base0, 8192);
      chk("rst_iter0", iter0, 0);
      chk("rst_busy0", busy0, 0);
      chk("rst_acq0", acq0, 0);
      chk("rst_dac1", dac1, 16350);
      rst = 1'b0;
      m_reset();

      // basic iteration: sigma=+1 from seed
      pert = 14'd100; gain = Q1; dir = 1'b1;
      run_iter(64'h0002_8000_0000_0000, 64'h0000_8000_0000_0000, 1, 0);
      chk("basic_base", base_o, 8194);
      chk("basic_iter", iter_o, 1);
      enable = 1'b0;
      @(negedge clk);
      chk("idle_busy", busy_o, 0);

      do_reset();
      dir = 1'b0;
      run_iter(64'h0002_8000_0000_0000, 64'h0000_8000_0000_0000, 1, 0);
      chk("dir0_base", base_o, 8190);

      // rounding: diff 0.5 rounds up to 1
      do_reset();
      dir = 1'b1;
      run_iter(64'h0000_C000_0000_0000, 64'h0000_4000_0000_0000, 1, 0);
      chk("round_base", base_o, 8193);

      // asynchronous reset in the middle of SETTLE_B
      enable = 1'b1;
      wait_acq(k);
      pulse(64'h0003_0000_0000_0000);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_dac", dac_o, 8192);
      chk("arst_base", base_o, 8192);
      chk("arst_iter", iter_o, 0);
      chk("arst_busy", busy_o, 0);
      chk("arst_acq", acq_o, 0);
      enable = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      m_reset();

      // enable dropped together with MEAS_VALID in MEAS_A
      enable = 1'b1;
      wait_acq(k);
      chk("abort_lat", k, S0 + 1);
      meas_in = 64'h0100_0000_0000_0000;
      meas_valid = 1'b1;
      enable = 1'b0;
      @(negedge clk);
      meas_valid = 1'b0;
      chk("abort_busy", busy_o, 0);
      chk("abort_dac", dac_o, m_base);
      chk("abort_iter", iter_o, m_iter);
      run_iter(64'h0002_8000_0000_0000, 64'h0000_8000_0000_0000, 1, 0);
      chk("abort_sigma", base_o, 8194);

      // stray strobes in IDLE and SETTLE_A
      enable = 1'b0;
      @(negedge clk);
      saved = dac_o;
      meas_in = 64'h7777_0000_0000_0000;
      meas_valid = 1'b1;
      repeat (2) @(negedge clk);
      meas_valid = 1'b0;
      chk("stray_busy", busy_o, 0);
      chk("stray_dac", dac_o, saved);
      run_iter(64'h0001_0000_0000_0000, 64'h0003_0000_0000_0000, 1, 1);

      // 1000 iterations with equal measurements: base must not move
      saved = m_base;
      for (int i = 0; i < 1000; i++) begin
         pert = 14'($urandom_range(0, 3000));
         gain = {$urandom, $urandom};
         dir  = 1'($urandom);
         ja   = {$urandom, $urandom};
         run_iter(ja, ja, 0, 0);
      end
      chk("const_base", base_o, saved);

      // random differences
      for (int i = 0; i < 40; i++) begin
         pert = 14'($urandom_range(0, 3000));
         gain = 64'($urandom_range(0, 1 << 20)) << 30;
         dir  = 1'($urandom);
         run_iter(64'($signed($urandom)) <<< 20, 64'($signed($urandom)) <<< 20, 0, 0);
      end
      enable = 1'b0;
      @(negedge clk);
      chk("end_busy", busy_o, 0);

      // clamp instance
      sel = 1'b1;
      do_reset();
      pert = 14'd100; gain = 64'h0064_0000_0000_0000; dir = 1'b1;
      run_iter(64'h00C8_0000_0000_0000, 64'h0, 1, 0);
      chk("clamp_base", base_o, 16383);
      enable = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
